// File: rtl/pipe_register.sv
// pipe_register: parametrised multi-stage register slice with valid/ready flow control.
//
// Each of the DEPTH stages holds one valid bit and one data word. Stage 0 faces
// the upstream side and stage DEPTH-1 drives the outputs. An empty stage always
// accepts its upstream word, so bubbles collapse even while the downstream is
// stalled. The pipe can therefore hold DEPTH words with out_ready low. With no
// stall the latency is DEPTH cycles and the throughput is one word per cycle.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset; clears every valid bit
//   flush      - synchronous discard of all held entries; blocks both handshakes
//   in_valid   - upstream data valid
//   in_ready   - slice accepts in_data this cycle
//   in_data    - upstream data word
//   out_valid  - out_data valid
//   out_ready  - downstream accepts out_data this cycle
//   out_data   - data word from the last stage
//   occupancy  - number of valid stages; not masked by flush
//
// Build option:
//   PIPE_REGISTER_DATA_RESET_EN - when defined, every data register resets
//   asynchronously to RESET_VAL. When undefined, the data registers have no
//   reset, and out_data is unknown until the first word reaches the last stage.

module pipe_register #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_up_v;
  logic [WIDTH-1:0] w_up_d [DEPTH];
  logic [OccW-1:0]  w_occ;

  // Stage i can take a new word when it is empty, when some stage ahead of it
  // is empty, or when the downstream pops. This flattened form is equivalent to
  // the chain rdy[i] = !v[i] | rdy[i+1].
  assign w_rdy[DEPTH] = out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign w_rdy[i] = out_ready | ~(&r_v[DEPTH-1:i]);
  end

  // Upstream view of each stage: external input for stage 0, previous stage otherwise.
  always_comb begin
    w_up_v    = '0;
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_up_v[i] = r_v[i-1];
      w_up_d[i] = r_d[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_up_v[i];
        end
      end
    end
  end

  // A data register loads only when a valid word moves in. This avoids
  // needless toggling and keeps out_data stable while a word is stalled.
`ifdef PIPE_REGISTER_DATA_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET_VAL;
      end
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i] && w_up_v[i]) begin
          r_d[i] <= w_up_d[i];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i] && w_up_v[i]) begin
          r_d[i] <= w_up_d[i];
        end
      end
    end
  end
`endif

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OccW'(r_v[i]);
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1] & ~flush;
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: scoreboard bench for pipe_register (WIDTH=8, DEPTH=3).
//
// The reference model is a FIFO of accepted words. Each word is tagged with the
// cycle it was accepted in. The expected behaviour follows from these rules:
//   - occupancy equals the number of words held in the FIFO.
//   - in_ready is high when flush is low and either the FIFO is not full or a
//     pop is possible.
//   - The head word is presented once DEPTH cycles have passed since it was
//     accepted. Earlier words block it only until they have been popped.
//   - flush empties the FIFO, and reset empties it immediately.
// The driver pushes accepted words into the FIFO. A separate negedge monitor
// compares the DUT outputs against the FIFO and pops the head on each output
// handshake.

module tb_pipe_register;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  pipe_register #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESET_VAL(8'hC3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   peak_occ = 0;
  bit   exp_in_rdy = 1'b0;
  bit   exp_ov = 1'b0;
  bit   last_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor at negedge: inputs are stable here and the DUT has settled.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      exp_in_rdy = !flush && ((sb.size() < D) || out_ready);
      exp_ov     = !flush && (sb.size() > 0) && (cyc >= sb[0].acc + D);
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      check("in_ready", 32'(in_ready), 32'(exp_in_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov && out_valid) begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
      end
      if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
      if (exp_ov && out_ready) begin
        void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus. The model is updated after the monitor has run for
  // this cycle and before the next rising edge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #6;
    last_acc = rst_n && v && exp_in_rdy;
    if (last_acc) sb.push_back('{data: d, acc: cyc});
    if (fl && rst_n) sb.delete();
  endtask

  // Assert reset between edges and check that it takes effect immediately.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_occ"}, 32'(occupancy), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef PIPE_REGISTER_DATA_RESET_EN
    check({tag, "_out_data_rst"}, 32'(out_data), 32'hC3);
`endif
    sb.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Initial reset: outputs must take their reset values while rst_n is low.
    #12;
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_REGISTER_DATA_RESET_EN
    check("rst_out_data", 32'(out_data), 32'hC3);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back stream with no stall.
    peak_occ = 0;
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_peak_occ", 32'(peak_occ), 32'd3);

    // Back-pressure: the fourth word must wait for the pipe to drain.
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    check("t2_occ_full", 32'(occupancy), 32'd3);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'hA4, k >= 2, 1'b0);
      if (last_acc) break;
    end
    check("t2_a4_accepted", 32'(last_acc), 32'd1);
    repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Full pipe with a simultaneous push and pop.
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    check("t3_in_ready_push_pop", 32'(in_ready), 32'd1);
    check("t3_occ_push_pop", 32'(occupancy), 32'd3);
    repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with an offered word: no handshake happens and the pipe empties.
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    check("t4_flush_in_ready", 32'(in_ready), 32'd0);
    check("t4_flush_out_valid", 32'(out_valid), 32'd0);
    check("t4_flush_occ_unmasked", 32'(occupancy), 32'd2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_occ_after_flush", 32'(occupancy), 32'd0);
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset while a word is held.
    drive(1'b1, 8'h7E, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_held_valid", 32'(out_valid), 32'd1);
    async_reset("t5");

    // Randomised traffic at several back-pressure levels, with occasional flushes.
    for (int phase = 0; phase < 3; phase++) begin
      int p_ready;
      p_ready = (phase == 0) ? 90 : ((phase == 1) ? 50 : 15);
      for (int n = 0; n < 300; n++) begin
        drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 99) < p_ready,
              $urandom_range(0, 99) < 3);
      end
    end
    async_reset("rnd");
    for (int n = 0; n < 200; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 99) < 70, 1'b0);
    end

    // Drain within a bounded number of cycles.
    for (int k = 0; k < 50 && sb.size() > 0; k++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
